// File: rtl/apb_requester.sv
// APB requester: accepts one valid/ready command at a time, runs a SETUP/ACCESS
// transfer, and returns a single-cycle response. Stalled completers are aborted by a timeout.
module apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, done, abort;

  assign cmd_ready = (state == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == ACCESS) && pready;
  // Abort only when the completer is still stalled; a late pready wins.
  assign abort     = (state == ACCESS) && !pready && TO_EN && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // APB strobes are registered from the next state so they change with it.
      psel      <= (state_nxt != IDLE);
      penable   <= (state_nxt == ACCESS);
      rsp_valid <= 1'b0;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_write ? cmd_wdata : '0;
        cnt    <= '0;
      end
      if ((state == ACCESS) && !pready) cnt <= cnt + CNT_W'(1);
      if (done) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: transfer-level model checked every cycle,
// plus literal latency/data expectations per transfer.
module tb_apb_requester;
  localparam int TO = 4;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transfer-level model: m_cyc counts cycles since acceptance (0 = no transfer).
  int          m_cyc = 0;
  logic        m_pwrite = 0, m_rsp_valid = 0, m_rsp_slverr = 0, m_rsp_timeout = 0;
  logic [31:0] m_paddr = 0, m_pwdata = 0, m_rsp_rdata = 0;

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_cyc = 0; m_pwrite = 0; m_paddr = 0; m_pwdata = 0;
      m_rsp_valid = 0; m_rsp_rdata = 0; m_rsp_slverr = 0; m_rsp_timeout = 0;
    end else begin
      m_rsp_valid = 0;
      if (m_cyc == 0) begin
        if (cmd_valid) begin
          m_cyc = 1; m_pwrite = cmd_write; m_paddr = cmd_addr;
          m_pwdata = cmd_write ? cmd_wdata : 32'h0;
        end
      end else if (m_cyc == 1) begin
        m_cyc = 2;
      end else if (pready) begin
        m_cyc = 0; m_rsp_valid = 1; m_rsp_rdata = m_pwrite ? 32'h0 : prdata;
        m_rsp_slverr = pslverr; m_rsp_timeout = 0;
      end else if (TO != 0 && (m_cyc - 1) == TO) begin
        m_cyc = 0; m_rsp_valid = 1; m_rsp_rdata = 0; m_rsp_slverr = 1; m_rsp_timeout = 1;
      end else begin
        m_cyc++;
      end
    end
  end

  always @(negedge pclk) begin
    chk("cmd_ready", cmd_ready, (m_cyc == 0) && !preset);
    chk("psel", psel, m_cyc > 0);
    chk("penable", penable, m_cyc >= 2);
    chk("pwrite", pwrite, m_pwrite);
    chk("paddr", paddr, m_paddr);
    chk("pwdata", pwdata, m_pwdata);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
    chk("rsp_slverr", rsp_slverr, m_rsp_slverr);
    chk("rsp_timeout", rsp_timeout, m_rsp_timeout);
  end

  // Completer: ready after c_waits wait states; junk on prdata/pslverr otherwise.
  int          c_waits = 0;
  int          acc_k = 0;
  logic [31:0] c_rdata = 0;
  logic        c_err = 0;

  always @(negedge pclk) begin
    if (psel && penable) acc_k = acc_k + 1; else acc_k = 0;
    if (psel && penable && acc_k > c_waits) begin
      pready = 1'b1; prdata = c_rdata; pslverr = c_err;
    end else begin
      pready = 1'b0; prdata = 32'hBAD0_0000; pslverr = 1'b1;
    end
  end

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input bit err, input bit hold,
                      input int exp_lat, input logic [31:0] exp_rdata,
                      input bit exp_err, input bit exp_to);
    int lat;
    int guard;
    c_waits = waits; c_rdata = rd; c_err = err;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge pclk); guard++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    lat = 0;
    do begin
      @(negedge pclk);
      lat++;
      if (lat == 1) begin
        if (!hold) cmd_valid = 1'b0;
        chk("setup_phase", {psel, penable}, 2'b10);
      end
      if (lat == 2) chk("access_phase", {psel, penable}, 2'b11);
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, exp_lat);
    chk("rsp_rdata_lit", rsp_rdata, exp_rdata);
    chk("rsp_slverr_lit", rsp_slverr, exp_err);
    chk("rsp_timeout_lit", rsp_timeout, exp_to);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0; cmd_wdata = 0;
    pready = 1'b0; prdata = 0; pslverr = 1'b0;
    @(negedge pclk);
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    #2 preset = 1'b0;
    @(negedge pclk);

    xfer(1, 32'h10, 32'hA5A5_0001, 0, 32'h7777_7777, 0, 0, 3, 32'h0, 0, 0);
    chk("pwdata_held", pwdata, 32'hA5A5_0001);
    xfer(0, 32'h04, 32'h1111_1111, 2, 32'hDEAD_BEEF, 0, 0, 5, 32'hDEAD_BEEF, 0, 0);
    chk("paddr_held", paddr, 32'h04);
    chk("pwdata_read", pwdata, 32'h0);
    xfer(0, 32'h08, 32'h0, 0, 32'h1111_2222, 1, 0, 3, 32'h1111_2222, 1, 0);
    xfer(1, 32'h0C, 32'h55, 0, 32'h9999, 0, 0, 3, 32'h0, 0, 0);
    xfer(0, 32'h30, 32'h0, 1000, 32'h1234, 0, 0, 6, 32'h0, 1, 1);
    xfer(0, 32'h34, 32'h0, 3, 32'hCAFE_F00D, 0, 0, 6, 32'hCAFE_F00D, 0, 0);
    xfer(1, 32'h20, 32'h0000_0020, 0, 32'h0, 0, 1, 3, 32'h0, 0, 0);
    xfer(0, 32'h24, 32'h0, 0, 32'h0BAD_CAFE, 0, 0, 3, 32'h0BAD_CAFE, 0, 0);
    repeat (2) @(negedge pclk);

    // Reset in the middle of a stalled read.
    c_waits = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 0;
    begin
      int g;
      g = 0;
      while (!penable && g < 20) begin
        @(negedge pclk); g++;
        if (psel) cmd_valid = 1'b0;
      end
    end
    chk("mid_access", {psel, penable}, 2'b11);
    cmd_valid = 1'b0;
    #2 preset = 1'b1;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    chk("async_cmd_ready", cmd_ready, 0);
    repeat (3) @(negedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    xfer(1, 32'h44, 32'h0000_BEEF, 1, 32'h0, 0, 0, 4, 32'h0, 0, 0);
    repeat (2) @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
